// File: rtl/data_mem_responder.sv
// Single-port 16-bit data memory serving the core's LOAD/STOR accesses.
// One request at a time: accept in IDLE, count wait states, access, then hold the response until taken.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        stall
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_count;
  logic                  r_write;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic [15:0]           r_mem [DEPTH];
  logic                  w_accept;
  logic                  w_access;
  logic                  w_range_err;
  logic                  w_addr_err;

  // Upper address bits beyond the memory must be zero; a 15-bit word address covers everything.
  generate
    if (ADDR_WIDTH < 15) begin : g_range
      assign w_range_err = |req_addr[15:ADDR_WIDTH+1];
    end else begin : g_full
      assign w_range_err = 1'b0;
    end
  endgenerate

  assign w_addr_err = req_addr[0] | w_range_err;
  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_access   = (r_state == S_WAIT) && (r_count == 4'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_WAIT;
      S_WAIT:  if (r_count == 4'd0) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_write <= 1'b0;
      r_error <= 1'b0;
      r_word  <= '0;
      r_wdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_count <= 4'(WAIT_STATES);
        r_write <= req_write;
        r_error <= w_addr_err;
        r_word  <= req_addr[ADDR_WIDTH:1];
        r_wdata <= req_wdata;
      end else if ((r_state == S_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  // Memory is never reset; a reset landing on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_write && !r_error) begin
      r_mem[r_word] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 16'h0000;
    end else if (w_access) begin
      r_rdata <= (r_write || r_error) ? 16'h0000 : r_mem[r_word];
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error && (r_state == S_RESP);
  assign stall     = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven requests on a WAIT_STATES=2 instance,
// hand-written reset/backpressure sequences, and a random stream on a WAIT_STATES=0 instance.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        v, rdy, w, rv, rr, re, st;
  logic [15:0] a, d, rd;
  logic        v0, rdy0, w0, rv0, rr0, re0, st0;
  logic [15:0] a0, d0, rd0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[11];

  logic [15:0] model [256];
  logic        r_wr, r_err;
  logic [15:0] r_ad, r_wd, r_er;
  int          r_lat, r_kind;
  exp_t        r_e, r_got;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(rst), .req_valid(v), .req_ready(rdy), .req_write(w),
    .req_addr(a), .req_wdata(d), .rsp_valid(rv), .rsp_ready(rr),
    .rsp_rdata(rd), .rsp_error(re), .stall(st)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .rsp_valid(rv0), .rsp_ready(rr0),
    .rsp_rdata(rd0), .rsp_error(re0), .stall(st0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the WAIT_STATES=2 instance; bp>0 holds rsp_ready low that many cycles
  // while trying to inject a store that must be ignored.
  task automatic req2(input string tag, input logic wr, input logic [15:0] ad,
                      input logic [15:0] wd, input logic [15:0] er, input logic ee, input int bp);
    exp_t e;
    exp_t got;
    int   lat;
    chk({tag, " ready_before"}, 32'(rdy), 32'd1);
    v = 1'b1; w = wr; a = ad; d = wd;
    @(posedge clk); #1;
    v = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000;
    e.rdata = er; e.err = ee;
    sb.push_back(e);
    chk({tag, " stall_after_accept"}, 32'(st), 32'd1);
    lat = 0;
    while (rv !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd3);
    if (sb.size() > 0) got = sb.pop_front();
    else begin got.rdata = 16'hxxxx; got.err = 1'bx; end
    $display("[TB] %s wr=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d", tag, wr, ad, wd, rd, re, lat);
    chk({tag, " rdata"}, 32'(rd), 32'(got.rdata));
    chk({tag, " error"}, 32'(re), 32'(got.err));
    for (int i = 0; i < bp; i++) begin
      v = 1'b1; w = 1'b1; a = 16'h0020; d = 16'hAAAA;
      @(posedge clk); #1;
      chk({tag, " bp_valid"}, 32'(rv), 32'd1);
      chk({tag, " bp_rdata"}, 32'(rd), 32'(got.rdata));
      chk({tag, " bp_stall"}, 32'(st), 32'd1);
      chk({tag, " bp_ready"}, 32'(rdy), 32'd0);
    end
    v = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000;
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    chk({tag, " idle_ready"}, 32'(rdy), 32'd1);
    chk({tag, " idle_stall"}, 32'(st), 32'd0);
    chk({tag, " idle_valid"}, 32'(rv), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 16'h0011, 16'h1111, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[6]  = '{1'b1, 16'h01FE, 16'hCAFE, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 16'h01FE, 16'h0000, 16'hCAFE, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 16'h8000, 16'h5555, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 16'h01FF, 16'h0000, 16'h0000, 1'b1};
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;

    rst = 1'b1;
    v = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000; rr = 1'b0;
    v0 = 1'b0; w0 = 1'b0; a0 = 16'h0000; d0 = 16'h0000; rr0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ready", 32'(rdy), 32'd1);
    chk("reset valid", 32'(rv), 32'd0);
    chk("reset stall", 32'(st), 32'd0);
    chk("reset rdata", 32'(rd), 32'd0);
    chk("reset error", 32'(re), 32'd0);
    chk("reset ready0", 32'(rdy0), 32'd1);

    for (int i = 0; i < 11; i++) begin
      req2($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, 0);
    end

    // Backpressure: 5 cycles of rsp_ready low, store pulses to 0x0020 must be dropped.
    req2("backpressure", 1'b0, 16'h01FE, 16'h0000, 16'hCAFE, 1'b0, 5);
    req2("bp_no_accept", 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 0);

    // Reset during WAIT of a store.
    v = 1'b1; w = 1'b1; a = 16'h0004; d = 16'h1234;
    @(posedge clk); #1;
    v = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000;
    chk("rst_wait stall", 32'(st), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset in WAIT: ready=%0d stall=%0d valid=%0d", rdy, st, rv);
    chk("rst_wait ready", 32'(rdy), 32'd1);
    chk("rst_wait stall_low", 32'(st), 32'd0);
    chk("rst_wait valid", 32'(rv), 32'd0);
    req2("rst_wait_load", 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 0);

    // Reset coinciding with the access edge: no write may happen.
    v = 1'b1; w = 1'b1; a = 16'h0006; d = 16'h7777;
    @(posedge clk); #1;
    v = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_access still_wait", 32'(rv), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_access ready", 32'(rdy), 32'd1);
    chk("rst_access valid", 32'(rv), 32'd0);
    req2("rst_access_load", 1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0, 0);

    // Random stream on the WAIT_STATES=0 instance with rsp_ready held high.
    for (int n = 0; n < 20; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_kind = int'($urandom_range(0, 9));
      r_ad   = 16'($urandom_range(0, 15)) << 1;
      if (r_kind == 7) r_ad = r_ad | 16'h0001;
      else if (r_kind == 8) r_ad = r_ad | 16'h0200;
      else if (r_kind == 9) r_ad = 16'hFFFE;
      r_wd   = 16'($urandom);
      r_err  = r_ad[0] | (|r_ad[15:9]);
      r_er   = (!r_wr && !r_err) ? model[r_ad[8:1]] : 16'h0000;
      if (r_wr && !r_err) model[r_ad[8:1]] = r_wd;
      r_e.rdata = r_er; r_e.err = r_err;

      chk($sformatf("rnd%0d ready", n), 32'(rdy0), 32'd1);
      v0 = 1'b1; w0 = r_wr; a0 = r_ad; d0 = r_wd;
      @(posedge clk); #1;
      v0 = 1'b0; w0 = 1'b0; a0 = 16'h0000; d0 = 16'h0000;
      sb.push_back(r_e);
      chk($sformatf("rnd%0d stall_wait", n), 32'(st0), 32'd1);
      r_lat = 0;
      while (rv0 !== 1'b1 && r_lat < 20) begin
        @(posedge clk); #1;
        r_lat++;
      end
      chk($sformatf("rnd%0d latency", n), 32'(r_lat), 32'd1);
      if (sb.size() > 0) r_got = sb.pop_front();
      else begin r_got.rdata = 16'hxxxx; r_got.err = 1'bx; end
      $display("[TB] rnd%0d wr=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               n, r_wr, r_ad, r_wd, rd0, re0, r_lat);
      chk($sformatf("rnd%0d rdata", n), 32'(rd0), 32'(r_got.rdata));
      chk($sformatf("rnd%0d error", n), 32'(re0), 32'(r_got.err));
      chk($sformatf("rnd%0d stall_resp", n), 32'(st0), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d stall_idle", n), 32'(st0), 32'd0);
      chk($sformatf("rnd%0d ready_idle", n), 32'(rdy0), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
